// File: rtl/seg_scan_pkg.sv
// Shared types and default constants for the multiplexed 7-segment scan controller.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  localparam int unsigned DEF_NUM_DIGITS   = 4;
  localparam int unsigned DEF_DWELL_CYCLES = 10_000;
  localparam int unsigned DEF_BLANK_CYCLES = 16;

endpackage

// File: rtl/seg_scan_timer.sv
// Loadable down-counter; done_c is high while the count sits at zero, so a
// load of N-1 yields a slot of exactly N cycles ending on the done cycle.
module seg_scan_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt;

  // Count register: load wins, then clear, then decrement to zero and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done_c = (cnt == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment digit scanner with blanking gap and frame-synchronous
// shadow update. Optional macro SEG_SCAN_LZB_EN enables leading-zero blanking.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int unsigned DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    upd_req,
  input  logic [4*NUM_DIGITS-1:0] upd_data,
  output logic                    upd_ack,
  output logic [3:0]              digit_val,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start
);

  localparam int unsigned DATA_W  = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  state_e                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [DATA_W-1:0]       shadow, shadow_nxt;
  logic [3:0]              val_nxt;
  logic [NUM_DIGITS-1:0]   sel_nxt;
  logic                    ack_nxt;
  logic                    fs_nxt;
  logic                    tmr_load;
  logic                    tmr_clr;
  logic [CNT_W-1:0]        tmr_val;
  logic                    tmr_done_c;
  logic                    show_en_c;
  logic [NUM_DIGITS-1:0]   onehot_c;

  seg_scan_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done_c   (tmr_done_c)
  );

  assign onehot_c = NUM_DIGITS'(1) << idx;

`ifdef SEG_SCAN_LZB_EN
  // Digit idx>0 stays dark when it and every more-significant nibble are zero.
  assign show_en_c = (idx == '0) || (|(shadow >> {idx, 2'b00}));
`else
  assign show_en_c = 1'b1;
`endif

  // Next-state and next-output logic for the IDLE/BLANK/SHOW scan sequence.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    shadow_nxt = shadow;
    val_nxt    = digit_val;
    sel_nxt    = '0;
    ack_nxt    = 1'b0;
    fs_nxt     = 1'b0;
    tmr_load   = 1'b0;
    tmr_clr    = 1'b0;
    tmr_val    = BLANK_LOAD;

    if (!ena) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
      tmr_clr   = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_BLANK;
          idx_nxt   = '0;
          tmr_load  = 1'b1;
          fs_nxt    = 1'b1;
          val_nxt   = shadow[3:0];
        end
        ST_BLANK: begin
          if (tmr_done_c) begin
            state_nxt = ST_SHOW;
            tmr_load  = 1'b1;
            tmr_val   = DWELL_LOAD;
            sel_nxt   = show_en_c ? onehot_c : '0;
          end
        end
        ST_SHOW: begin
          if (tmr_done_c) begin
            state_nxt = ST_BLANK;
            tmr_load  = 1'b1;
            if (idx == LAST_IDX) begin
              idx_nxt = '0;
              fs_nxt  = 1'b1;
              if (upd_req) begin
                shadow_nxt = upd_data;
                ack_nxt    = 1'b1;
              end
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
            val_nxt = shadow_nxt[{idx_nxt, 2'b00} +: 4];
          end else begin
            sel_nxt = show_en_c ? onehot_c : '0;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, shadow and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      shadow      <= '0;
      digit_val   <= '0;
      digit_sel   <= '0;
      upd_ack     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      shadow      <= shadow_nxt;
      digit_val   <= val_nxt;
      digit_sel   <= sel_nxt;
      upd_ack     <= ack_nxt;
      frame_start <= fs_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, dwell 8, blank 2) against a
// frame-position reference model. Honours SEG_SCAN_LZB_EN when defined.
module tb_seg_scan_ctrl;

  localparam int unsigned ND     = 4;
  localparam int unsigned DWELL  = 8;
  localparam int unsigned BLANK  = 2;
  localparam int unsigned SLOT   = DWELL + BLANK;
  localparam int unsigned PERIOD = ND * SLOT;

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic          upd_req;
  logic [15:0]   upd_data;
  logic          upd_ack;
  logic [3:0]    digit_val;
  logic [ND-1:0] digit_sel;
  logic          frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position within the frame plus the displayed shadow.
  bit          active;
  int          t;
  logic [15:0] mshadow;
  logic [3:0]  exp_val;
  bit          exp_ack;

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .upd_req     (upd_req),
    .upd_data    (upd_data),
    .upd_ack     (upd_ack),
    .digit_val   (digit_val),
    .digit_sel   (digit_sel),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    active  = 0;
    t       = 0;
    mshadow = '0;
    exp_val = '0;
    exp_ack = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    exp_ack = 0;
    if (!ena) begin
      active = 0;
      t      = 0;
    end else if (!active) begin
      active = 1;
      t      = 0;
    end else begin
      t = (t + 1) % PERIOD;
      if (t == 0 && upd_req) begin
        mshadow = upd_data;
        exp_ack = 1;
      end
    end
    if (active) exp_val = mshadow[4*(t/SLOT) +: 4];
  endtask

  function automatic logic [ND-1:0] exp_sel();
    int d;
    logic [ND-1:0] s;
    if (!active || (t % SLOT) < BLANK) return '0;
    d = t / SLOT;
    s = ND'(1) << d;
`ifdef SEG_SCAN_LZB_EN
    if (d > 0 && (mshadow >> (4*d)) == 16'd0) s = '0;
`endif
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check("digit_sel", 32'(digit_sel), 32'(exp_sel()));
    check("digit_val", 32'(digit_val), 32'(exp_val));
    check("frame_start", 32'(frame_start), 32'(active && t == 0));
    check("upd_ack", 32'(upd_ack), 32'(exp_ack));
  endtask

  // Step with idle request until the model reaches frame position tgt.
  task automatic run_to(input int tgt);
    int n = 0;
    upd_req = 0;
    ena     = 1;
    do begin
      step();
      n++;
    end while (!(active && t == tgt) && n < 2 * PERIOD);
    if (!(active && t == tgt)) check("run_to_timeout", 32'(t), 32'(tgt));
  endtask

  // Request an update and hold it until the model predicts the ack.
  task automatic load_shadow(input logic [15:0] d, input string tag);
    int n = 0;
    upd_data = d;
    upd_req  = 1;
    do begin
      step();
      n++;
    end while (!exp_ack && n < 2 * PERIOD);
    upd_req = 0;
    check(tag, 32'(exp_ack), 32'(1));
  endtask

  function automatic logic [15:0] rand_data();
    logic [15:0] d;
    d = 16'($urandom);
    for (int i = 0; i < 4; i++)
      if ($urandom_range(0, 1) == 1) d[4*i +: 4] = 4'h0;
    return d;
  endfunction

  initial begin
    int off;
    logic new_ena;
    logic new_req;

    rst_n    = 0;
    ena      = 0;
    upd_req  = 0;
    upd_data = '0;
    model_reset();

    #12;
    check("rst_sel", 32'(digit_sel), 32'(0));
    check("rst_val", 32'(digit_val), 32'(0));
    check("rst_ack", 32'(upd_ack), 32'(0));
    check("rst_fs", 32'(frame_start), 32'(0));

    @(negedge clk);
    rst_n = 1;
    ena   = 1;
    step();
    check("first_frame_start", 32'(frame_start), 32'(1));
    for (int i = 0; i < PERIOD + 5; i++) step();

    // Level request mid-frame: ack only at the next frame boundary.
    run_to(15);
    load_shadow(16'h1234, "ack_1234_seen");
    for (int i = 0; i < PERIOD; i++) step();

    // Short pulse mid-frame must not load.
    run_to(5);
    upd_data = 16'h9999;
    upd_req  = 1;
    for (int i = 0; i < 3; i++) step();
    upd_req = 0;
    for (int i = 0; i < PERIOD + 5; i++) step();

    // Leading-zero pattern.
    run_to(10);
    load_shadow(16'h0050, "ack_0050_seen");
    for (int i = 0; i < 2 * PERIOD; i++) step();
    load_shadow(16'h1234, "ack_reload_seen");

    // Enable drop during SHOW of digit 2, then restart.
    run_to(24);
    ena = 0;
    step();
    check("ena_drop_sel", 32'(digit_sel), 32'(0));
    step();
    ena = 1;
    step();
    check("restart_fs", 32'(frame_start), 32'(1));
    for (int i = 0; i < PERIOD; i++) step();

    // Asynchronous reset in the middle of a SHOW slot.
    run_to(25);
    #2;
    rst_n = 0;
    #1;
    check("async_rst_sel", 32'(digit_sel), 32'(0));
    check("async_rst_val", 32'(digit_val), 32'(0));
    check("async_rst_ack", 32'(upd_ack), 32'(0));
    check("async_rst_fs", 32'(frame_start), 32'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < PERIOD; i++) step();

    // Randomized enable drops and level requests.
    off = 0;
    for (int i = 0; i < 3000; i++) begin
      if (off == 0 && $urandom_range(0, 199) == 0) off = $urandom_range(1, 5);
      if (off > 0) begin
        new_ena = 0;
        off--;
      end else begin
        new_ena = 1;
      end
      new_req = upd_req;
      if ($urandom_range(0, 19) == 0) new_req = !upd_req;
      if (!new_ena || !ena) new_req = 0;
      if (new_req && !upd_req) upd_data = rand_data();
      ena     = new_ena;
      upd_req = new_req;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
